mpsoc_instr_mem_arbiter: RTL and testbench
==========================================

# mpsoc_instr_mem_arbiter

Two-master arbiter that shares one single-port on-chip instruction memory (16384 × 32, byte-enabled, one-cycle read latency) between two Avalon-MM masters, e.g. the instruction ports of two CPUs in the MPSoC. It sits between the masters and the memory slave. It grants at most one access per cycle using round-robin, stalls the loser with `waitrequest`, and returns read data with `readdatavalid` exactly one cycle after acceptance.

## Interface
Parameters:
- `ADDR_W`, 14, word address width; memory depth is 2^ADDR_W.
- `DATA_W`, 32, data width; byteenable width is DATA_W/8.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `m0_address` / `m1_address`  in  ADDR_W  master word address.
- `m0_read` / `m1_read`  in  1  read request.
- `m0_write` / `m1_write`  in  1  write request.
- `m0_byteenable` / `m1_byteenable`  in  DATA_W/8  write byte lanes.
- `m0_writedata` / `m1_writedata`  in  DATA_W  write data.
- `m0_waitrequest` / `m1_waitrequest`  out  1  request not accepted this cycle.
- `m0_readdata` / `m1_readdata`  out  DATA_W  read data.
- `m0_readdatavalid` / `m1_readdatavalid`  out  1  readdata valid this cycle.
- `mem_address`  out  ADDR_W  to memory address.
- `mem_byteenable`  out  DATA_W/8  to memory byteenable.
- `mem_chipselect`  out  1  access this cycle.
- `mem_write`  out  1  write strobe.
- `mem_writedata`  out  DATA_W  write data.
- `mem_clken`  out  1  memory clock enable.
- `mem_readdata`  in  DATA_W  memory output; valid the cycle after the address is presented.

## Operation
- `reqX = mX_read | mX_write`.
- **Grant (combinational):**
  - Only one master requesting: it wins.
  - Both requesting: the master not granted last wins.
  - `last` is a 1-bit register, reset to 1, so m0 wins the first tie.
- **Pointer update:** `last` loads the winner's index only on cycles with a grant; otherwise it holds.
- **Waitrequest:**
  - Winner: `mX_waitrequest` = 0.
  - Requesting loser: 1.
  - Idle master: 0. Don't care, but driven 0.
  - While `reset_n` = 0, both are 1.
- **Memory mux:**
  - `mem_address`, `mem_byteenable` and `mem_writedata` come from the winner; they hold the m0 values when there is no grant.
  - `mem_chipselect` = any grant.
  - `mem_write` = winner's `write`.
  - For reads, `mem_byteenable` is forced to all ones.
- **Read and write asserted together on one master:** this is illegal; the write takes priority and no readdatavalid is generated.
- **Read tracking:** registers `rv[1:0]`. `rvX` is set on the edge ending a cycle in which mX was granted a read; otherwise it is cleared.
- **Read return:**
  - `mX_readdatavalid` = `rvX`.
  - `mX_readdata` = `mem_readdata` when `rvX`, else 0.
  - Both masters are never valid in the same cycle.
- **Clock enable:** `mem_clken` = `reset_n`, so the memory is frozen during reset.
- **No buffering:** a master that sees `waitrequest` must hold its request unchanged until accepted (Avalon rule); the arbiter stores no request state.

## Timing
- **Reset values** (registers, next edge with `reset_n` = 0):
  - `last` = 1, `rv` = 00.
  - Outputs: both readdatavalid 0, both readdata 0, both waitrequest 1, `mem_chipselect` 0, `mem_write` 0, `mem_clken` 0.
- **Accepted read:** a read accepted in cycle N (`waitrequest` low) gives `readdatavalid` = 1 in cycle N+1 with the data from that address. Latency is fixed at 1.
- **Throughput:** one access per cycle total. Back-to-back reads from one master with no contention give readdatavalid every cycle.
- **Contention:** with both masters requesting continuously, grants alternate m0, m1, m0, … The maximum wait for either master is 1 cycle.
- **Accepted write:** accepted in cycle N; the memory is updated at the end of N. A read of the same address granted in N+1 returns the new data.
- **Reset mid-operation:** a read granted in cycle N with `reset_n` = 0 at the end of N produces no readdatavalid in N+1.
- **Address range:** addresses cover the full 0 to 2^ADDR_W−1 range; there is no wrap logic in the arbiter.

## Test plan
- **Reset:**
  - Stimulus: hold `reset_n` = 0 for 3 cycles with both masters requesting.
  - Required: both waitrequest = 1, `mem_chipselect` = 0 and readdatavalid = 0 throughout; first grant after release goes to m0.
- **Single-master read:**
  - Stimulus: m0 writes 0xDEADBEEF to 0x0010 (byteenable 1111), then reads 0x0010.
  - Required: waitrequest 0 on both accesses; `m0_readdatavalid` = 1 exactly one cycle after the read, with 0xDEADBEEF; m1 outputs stay idle.
- **Contention:**
  - Stimulus: both masters issue continuous reads (m0 at 0x0000 up, m1 at 0x1000 up) for 8 cycles.
  - Required: grants strictly alternate starting with m0; each master gets 4 valid returns with the correct data; never two readdatavalids in the same cycle.
- **Byte enables:**
  - Stimulus: write 0x11223344 to 0x3FFF, then m1 writes 0xAABBCCDD with byteenable 0101, then m0 reads 0x3FFF.
  - Required: m0 returns 0x11BB33DD.
- **Reset mid-read:**
  - Stimulus: m1 read granted in cycle N, `reset_n` low at the end of N.
  - Required: `m1_readdatavalid` = 0 in N+1; `last` = 1 afterwards.
- **Illegal read and write together:**
  - Stimulus: m0 asserts read and write together with writedata 0x5A5A5A5A at 0x0020.
  - Required: memory is written, no readdatavalid; a later read of 0x0020 returns 0x5A5A5A5A.

Source files
------------

// File: rtl/mpsoc_instr_mem_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory between two
// Avalon-MM masters; read data returns one cycle after acceptance.
module mpsoc_instr_mem_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);

   logic       last;
   logic [1:0] rv;
   logic       req0, req1;
   logic       gnt0, gnt1, any_gnt;
   logic       sel_write;

   // Grants are suppressed while in reset so nothing reaches the memory.
   always_comb begin
      req0      = m0_read | m0_write;
      req1      = m1_read | m1_write;
      gnt0      = reset_n & req0 & (~req1 | last);
      gnt1      = reset_n & req1 & (~req0 | ~last);
      any_gnt   = gnt0 | gnt1;
      sel_write = gnt1 ? m1_write : m0_write;
   end

   always_comb begin
      m0_waitrequest = ~reset_n | (req0 & ~gnt0);
      m1_waitrequest = ~reset_n | (req1 & ~gnt1);
      mem_address    = gnt1 ? m1_address   : m0_address;
      mem_writedata  = gnt1 ? m1_writedata : m0_writedata;
      mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
      if (any_gnt && !sel_write)
         mem_byteenable = '1;
      mem_chipselect = any_gnt;
      mem_write      = any_gnt & sel_write;
      mem_clken      = reset_n;
   end

   // A read+write on one master is treated as a write: no return tracked.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last <= 1'b1;
         rv   <= '0;
      end else begin
         if (any_gnt)
            last <= gnt1;
         rv <= {gnt1 & m1_read & ~m1_write, gnt0 & m0_read & ~m0_write};
      end
   end

   always_comb begin
      m0_readdatavalid = rv[0];
      m1_readdatavalid = rv[1];
      m0_readdata      = rv[0] ? mem_readdata : '0;
      m1_readdata      = rv[1] ? mem_readdata : '0;
   end

endmodule

// File: tb/tb_mpsoc_instr_mem_arbiter.sv
// Bench for mpsoc_instr_mem_arbiter: directed vector table, hand sequences for
// reset-mid-read and contention, and random traffic against a reference model.
module tb_mpsoc_instr_mem_arbiter;
   localparam int AW = 14;
   localparam int DW = 32;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [13:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
   } mreq_t;

   typedef struct {
      bit          rst;
      mreq_t       q0;
      mreq_t       q1;
      bit          wq0, wq1, cs, mw, rv0, rv1;
      logic [31:0] rd;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic [AW-1:0] m0_address, m1_address, mem_address;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [3:0]    m0_byteenable, m1_byteenable, mem_byteenable;
   logic [DW-1:0] m0_writedata, m1_writedata, mem_writedata;
   logic          m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata, mem_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic          mem_chipselect, mem_write, mem_clken;

   mpsoc_instr_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   // Single-port byte-enabled memory, one-cycle read latency, gated by clken.
   logic [31:0] bmem [0:16383];
   logic [31:0] mem_q;
   assign mem_readdata = mem_q;
   always @(posedge clk) begin
      if (mem_clken) begin
         if (mem_chipselect && mem_write)
            for (int i = 0; i < 4; i++)
               if (mem_byteenable[i]) bmem[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
         mem_q <= bmem[mem_address];
      end
   end

   // Reference model state
   logic [31:0] ref_mem [0:16383];
   int          ref_last;
   logic [1:0]  exp_rv;
   logic [31:0] exp_rd [2];

   int passed = 0;
   int total  = 0;

   function automatic logic [31:0] init_word(input int unsigned i);
      return (i * 32'h9E3779B1) ^ 32'h0F0F1234;
   endfunction

   function automatic mreq_t rq_idle();
      mreq_t q;
      q.rd = 0; q.wr = 0; q.a = '0; q.be = '0; q.wd = '0;
      return q;
   endfunction
   function automatic mreq_t rq_rd(input logic [13:0] a);
      mreq_t q;
      q = rq_idle(); q.rd = 1; q.a = a;
      return q;
   endfunction
   function automatic mreq_t rq_wr(input logic [13:0] a, input logic [3:0] be, input logic [31:0] wd);
      mreq_t q;
      q = rq_idle(); q.wr = 1; q.a = a; q.be = be; q.wd = wd;
      return q;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One bus cycle: drive at negedge, check just after, then advance the model.
   task automatic cyc(input bit rst, input mreq_t q0, input mreq_t q1, input bit late, output int w);
      bit    r0, r1;
      mreq_t q;
      @(negedge clk);
      reset_n = rst;
      m0_read = q0.rd; m0_write = q0.wr; m0_address = q0.a; m0_byteenable = q0.be; m0_writedata = q0.wd;
      m1_read = q1.rd; m1_write = q1.wr; m1_address = q1.a; m1_byteenable = q1.be; m1_writedata = q1.wd;
      #1;
      r0 = q0.rd | q0.wr;
      r1 = q1.rd | q1.wr;
      if (!rst)          w = -1;
      else if (r0 && r1) w = 1 - ref_last;
      else if (r0)       w = 0;
      else if (r1)       w = 1;
      else               w = -1;
      check("m0_waitrequest", m0_waitrequest, !rst || (r0 && w != 0));
      check("m1_waitrequest", m1_waitrequest, !rst || (r1 && w != 1));
      check("mem_chipselect", mem_chipselect, w >= 0);
      check("mem_write", mem_write, (w == 0) ? q0.wr : (w == 1) ? q1.wr : 1'b0);
      check("m0_readdatavalid", m0_readdatavalid, exp_rv[0]);
      check("m1_readdatavalid", m1_readdatavalid, exp_rv[1]);
      check("m0_readdata", m0_readdata, exp_rv[0] ? exp_rd[0] : 32'h0);
      check("m1_readdata", m1_readdata, exp_rv[1] ? exp_rd[1] : 32'h0);
      if (late) begin
         #3;
         reset_n = 1'b0;
      end
      exp_rv = '0;
      if (!rst || late) begin
         ref_last = 1;
      end else if (w >= 0) begin
         q = (w == 1) ? q1 : q0;
         if (q.wr) begin
            for (int unsigned b = 0; b < 4; b++)
               if (q.be[b]) ref_mem[q.a][8*b +: 8] = q.wd[8*b +: 8];
         end else if (q.rd) begin
            exp_rv[w] = 1'b1;
            exp_rd[w] = ref_mem[q.a];
         end
         ref_last = w;
      end
   endtask

   function automatic mreq_t rand_req();
      int unsigned p;
      logic [13:0] a;
      mreq_t q;
      p = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 0) a = 14'($urandom_range(0, 31));
      else                           a = 14'h3FFF - 14'($urandom_range(0, 3));
      q = rq_idle();
      if (p >= 4 && p <= 6) q = rq_rd(a);
      else if (p >= 7) begin
         q = rq_wr(a, 4'($urandom_range(0, 15)), $urandom);
         q.rd = (p == 9);
      end
      return q;
   endfunction

   vec_t  tbl [16];
   mreq_t idl, h0, h1;
   int    w, n0, n1, cnt0, cnt1;
   bit    st0, st1, rst;

   initial begin
      for (int unsigned i = 0; i < 16384; i++) begin
         bmem[i]    = init_word(i);
         ref_mem[i] = init_word(i);
      end
      ref_last = 1;
      exp_rv   = '0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      idl = rq_idle();
      reset_n = 1'b0;
      m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
      m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
      repeat (2) @(posedge clk);

      //            rst q0                                   q1                        wq0 wq1 cs mw rv0 rv1 rd
      for (int i = 0; i < 3; i++)
         tbl[i] = '{0, rq_rd(14'h0000), rq_rd(14'h1000), 1, 1, 0, 0, 0, 0, 32'h0};
      tbl[3]  = '{1, rq_rd(14'h0000), rq_rd(14'h1000), 0, 1, 1, 0, 0, 0, 32'h0};
      tbl[4]  = '{1, idl, rq_rd(14'h1000), 0, 0, 1, 0, 1, 0, init_word(0)};
      tbl[5]  = '{1, rq_wr(14'h0010, 4'hF, 32'hDEADBEEF), idl, 0, 0, 1, 1, 0, 1, init_word(32'h1000)};
      tbl[6]  = '{1, rq_rd(14'h0010), idl, 0, 0, 1, 0, 0, 0, 32'h0};
      tbl[7]  = '{1, idl, idl, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF};
      tbl[8]  = '{1, rq_wr(14'h3FFF, 4'hF, 32'h11223344), idl, 0, 0, 1, 1, 0, 0, 32'h0};
      tbl[9]  = '{1, idl, rq_wr(14'h3FFF, 4'b0101, 32'hAABBCCDD), 0, 0, 1, 1, 0, 0, 32'h0};
      tbl[10] = '{1, rq_rd(14'h3FFF), idl, 0, 0, 1, 0, 0, 0, 32'h0};
      tbl[11] = '{1, idl, idl, 0, 0, 0, 0, 1, 0, 32'h11BB33DD};
      tbl[12] = '{1, rq_wr(14'h0020, 4'hF, 32'h5A5A5A5A), idl, 0, 0, 1, 1, 0, 0, 32'h0};
      tbl[12].q0.rd = 1;
      tbl[13] = '{1, idl, idl, 0, 0, 0, 0, 0, 0, 32'h0};
      tbl[14] = '{1, rq_rd(14'h0020), idl, 0, 0, 1, 0, 0, 0, 32'h0};
      tbl[15] = '{1, idl, idl, 0, 0, 0, 0, 1, 0, 32'h5A5A5A5A};

      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].rst, tbl[i].q0, tbl[i].q1, 0, w);
         check($sformatf("vec%0d wq0", i), m0_waitrequest, tbl[i].wq0);
         check($sformatf("vec%0d wq1", i), m1_waitrequest, tbl[i].wq1);
         check($sformatf("vec%0d cs", i), mem_chipselect, tbl[i].cs);
         check($sformatf("vec%0d mw", i), mem_write, tbl[i].mw);
         check($sformatf("vec%0d rv0", i), m0_readdatavalid, tbl[i].rv0);
         check($sformatf("vec%0d rv1", i), m1_readdatavalid, tbl[i].rv1);
         if (tbl[i].rv0) check($sformatf("vec%0d rd0", i), m0_readdata, tbl[i].rd);
         if (tbl[i].rv1) check($sformatf("vec%0d rd1", i), m1_readdata, tbl[i].rd);
      end

      // m1 read accepted, reset asserted just before the closing edge
      cyc(1, idl, rq_rd(14'h1005), 1, w);
      cyc(0, idl, idl, 0, w);
      check("midrst_rdv1", m1_readdatavalid, 1'b0);

      // continuous contention; pointer must be back at 1 so m0 goes first
      n0 = 0; n1 = 0; cnt0 = 0; cnt1 = 0;
      for (int k = 0; k < 9; k++) begin
         if (k < 8) cyc(1, rq_rd(14'(n0)), rq_rd(14'(32'h1000 + n1)), 0, w);
         else       cyc(1, idl, idl, 0, w);
         if (k < 8) begin
            check($sformatf("contention%0d m0_wait", k), m0_waitrequest, k % 2);
            check($sformatf("contention%0d m1_wait", k), m1_waitrequest, 1 - (k % 2));
            if (w == 0) n0++;
            else        n1++;
         end
         cnt0 += int'(m0_readdatavalid);
         cnt1 += int'(m1_readdatavalid);
      end
      check("contention m0 returns", cnt0, 4);
      check("contention m1 returns", cnt1, 4);

      // random traffic obeying the hold-until-accepted rule
      st0 = 0; st1 = 0;
      h0 = idl; h1 = idl;
      for (int k = 0; k < 400; k++) begin
         if (!st0) h0 = rand_req();
         if (!st1) h1 = rand_req();
         rst = ($urandom_range(0, 49) != 0);
         cyc(rst, h0, h1, 0, w);
         st0 = rst && (h0.rd || h0.wr) && (w != 0);
         st1 = rst && (h1.rd || h1.wr) && (w != 1);
      end
      cyc(1, idl, idl, 0, w);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
